// File: rtl/lmsm_expander_pkg.sv
// Shared opcode constants, expander state encoding and mask helpers.
package lmsm_expander_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b1100;
    localparam logic [3:0] OP_SM = 4'b1101;
    localparam logic [3:0] OP_LA = 4'b1110;
    localparam logic [3:0] OP_SA = 4'b1111;

    typedef enum logic {
        StIdle   = 1'b0,
        StExpand = 1'b1
    } state_e;

    // Number of set mask bits strictly below position idx.
    function automatic logic [2:0] rank_below(input logic [7:0] mask, input logic [2:0] idx);
        logic [2:0] n;
        n = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if ((b < int'(idx)) && mask[b]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lmsm_ffs8.sv
// Lowest-set-bit encoder over an 8-bit mask.
module lmsm_ffs8 (
    input  logic [7:0] bits_i,
    output logic [2:0] idx_o,
    output logic       found_o
);

    always_comb begin
        idx_o   = 3'd0;
        found_o = 1'b0;
        // Descending scan so the lowest set bit is the last one written.
        for (int b = 7; b >= 0; b--) begin
            if (bits_i[b]) begin
                idx_o   = 3'(b);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_expander.sv
// Expands LM/SM/LA/SA into per-register LW/SW micro-ops; other instructions pass through.
module lmsm_expander
    import lmsm_expander_pkg::*;
(
    input  logic        clk1,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_ir,
    input  logic [15:0] in_npc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_ir,
    output logic [15:0] out_npc,
    output logic        out_uop,
    output logic        out_last,
    input  logic        out_ready
);

    state_e     state_q;
    logic [7:0] pend_q;
    logic [2:0] ra_q;
    logic [2:0] cnt_q;
    logic [2:0] defer_k_q;
    logic       load_q;
    logic       defer_q;

    logic [3:0] in_op;
    logic       in_multi;
    logic       in_load;
    logic [7:0] in_mask;
    logic [2:0] in_ra;
    logic       in_defer;
    logic [7:0] in_pend;

    logic       idle;
    logic       load_out;
    logic       accept;

    logic [7:0] sel_pend;
    logic [2:0] sel_ra;
    logic [2:0] sel_cnt;
    logic [2:0] sel_defer_k;
    logic       sel_load;
    logic       sel_defer;

    logic [2:0] ffs_idx;
    logic       ffs_found;

    logic [2:0]  uop_i;
    logic [2:0]  uop_k;
    logic [7:0]  uop_pend;
    logic        uop_defer;
    logic        uop_last;
    logic        uop_any;
    logic [15:0] uop_ir;
    logic [2:0]  cnt_d;

    assign in_op    = in_ir[15:12];
    assign in_multi = (in_op[3:2] == 2'b11);
    assign in_load  = in_multi && !in_op[0];
    assign in_mask  = in_op[1] ? 8'hFF : in_ir[7:0];
    assign in_ra    = in_ir[11:9];
    // A load that overwrites its own base register is held back until the end.
    assign in_defer = in_load && in_mask[in_ra];
    assign in_pend  = in_defer ? (in_mask & ~(8'b1 << in_ra)) : in_mask;

    assign idle     = (state_q == StIdle);
    assign load_out = !out_valid || out_ready;
    assign in_ready = idle && load_out;
    assign accept   = in_valid && in_ready;

    // In IDLE the first micro-op is built straight from the incoming instruction.
    assign sel_pend    = idle ? in_pend : pend_q;
    assign sel_ra      = idle ? in_ra : ra_q;
    assign sel_cnt     = idle ? 3'd0 : cnt_q;
    assign sel_defer_k = idle ? rank_below(in_mask, in_ra) : defer_k_q;
    assign sel_load    = idle ? in_load : load_q;
    assign sel_defer   = idle ? in_defer : defer_q;

    lmsm_ffs8 u_ffs8 (
        .bits_i  (sel_pend),
        .idx_o   (ffs_idx),
        .found_o (ffs_found)
    );

    always_comb begin
        uop_i     = sel_ra;
        uop_k     = sel_defer_k;
        uop_pend  = 8'h00;
        uop_defer = 1'b0;
        if (ffs_found) begin
            uop_i     = ffs_idx;
            // Count the deferred base register if it sits below this one.
            uop_k     = sel_cnt + {2'b00, (sel_defer && (sel_ra < ffs_idx))};
            uop_pend  = sel_pend & ~(8'b1 << ffs_idx);
            uop_defer = sel_defer;
        end
        uop_last = (uop_pend == 8'h00) && !uop_defer;
        uop_any  = ffs_found || sel_defer;
        uop_ir   = {(sel_load ? OP_LW : OP_SW), uop_i, sel_ra, 3'b000, uop_k};
        cnt_d    = sel_cnt + {2'b00, ffs_found};
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q   <= StIdle;
            pend_q    <= 8'h00;
            ra_q      <= 3'd0;
            cnt_q     <= 3'd0;
            defer_k_q <= 3'd0;
            load_q    <= 1'b0;
            defer_q   <= 1'b0;
            out_valid <= 1'b0;
            out_ir    <= 16'h0000;
            out_npc   <= 16'h0000;
            out_uop   <= 1'b0;
            out_last  <= 1'b0;
        end else if (flush) begin
            state_q   <= StIdle;
            pend_q    <= 8'h00;
            cnt_q     <= 3'd0;
            defer_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !in_multi) begin
                out_valid <= 1'b1;
                out_ir    <= in_ir;
                out_npc   <= in_npc;
                out_uop   <= 1'b0;
                out_last  <= 1'b1;
            end else if ((accept && uop_any) || (!idle && load_out)) begin
                out_valid <= 1'b1;
                out_ir    <= uop_ir;
                out_uop   <= 1'b1;
                out_last  <= uop_last;
                if (idle) begin
                    out_npc <= in_npc;
                end
                pend_q    <= uop_pend;
                defer_q   <= uop_defer;
                cnt_q     <= cnt_d;
                ra_q      <= sel_ra;
                load_q    <= sel_load;
                defer_k_q <= sel_defer_k;
                state_q   <= uop_last ? StIdle : StExpand;
            end
        end
    end

endmodule

// File: tb/tb_lmsm_expander.sv
// Scoreboard bench for lmsm_expander: directed instructions, queued expectations.
module tb_lmsm_expander;

    logic        clk1;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_ir;
    logic [15:0] in_npc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_npc;
    logic        out_uop;
    logic        out_last;
    logic        out_ready;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic        uop;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   waits;

    lmsm_expander dut (
        .clk1      (clk1),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ir     (in_ir),
        .in_npc    (in_npc),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ir    (out_ir),
        .out_npc   (out_npc),
        .out_uop   (out_uop),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] npc, input logic uop,
                        input logic last);
        exp_t e;
        e.ir = ir; e.npc = npc; e.uop = uop; e.last = last;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Presents one instruction and returns one step after the accepting edge.
    task automatic send(input logic [15:0] ir, input logic [15:0] npc, output int nwait);
        in_valid = 1'b1;
        in_ir    = ir;
        in_npc   = npc;
        #1;
        nwait = 0;
        while (!in_ready && nwait < 50) begin
            tick();
            nwait++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every completed output handshake pops one expectation.
    initial begin
        forever begin
            @(negedge clk1);
            if (!reset && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_ir), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_ir", 32'(out_ir), 32'(mon_e.ir));
                    check("out_npc", 32'(out_npc), 32'(mon_e.npc));
                    check("uop_last", {30'd0, out_uop, out_last}, {30'd0, mon_e.uop, mon_e.last});
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ir = 16'h0; in_npc = 16'h0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ir", 32'(out_ir), 32'h0);
        check("rst_npc", 32'(out_npc), 32'h0);
        check("rst_uop_last", {30'd0, out_uop, out_last}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Pass-through ADD
        push(16'h1298, 16'h0011, 1'b0, 1'b1);
        send(16'h1298, 16'h0011, waits);
        check("pt_valid", 32'(out_valid), 32'd1);
        check("pt_in_ready", 32'(in_ready), 32'd1);
        tick();

        // LM with base register R2 in the mask: R2 load goes last
        push(16'h4280, 16'h0020, 1'b1, 1'b0);
        push(16'h4882, 16'h0020, 1'b1, 1'b0);
        push(16'h4481, 16'h0020, 1'b1, 1'b1);
        send(16'hC416, 16'h0020, waits);
        check("lm_in_ready_c1", 32'(in_ready), 32'd0);
        tick();
        check("lm_in_ready_c2", 32'(in_ready), 32'd0);
        tick();
        check("lm_in_ready_c3", 32'(in_ready), 32'd1);
        tick();

        // SM under backpressure
        out_ready = 1'b0;
        push(16'h50C0, 16'h0030, 1'b1, 1'b0);
        push(16'h5EC1, 16'h0030, 1'b1, 1'b1);
        send(16'hD681, 16'h0030, waits);
        for (int c = 0; c < 3; c++) begin
            check("sm_hold_ir", 32'(out_ir), 32'h50C0);
            check("sm_hold_valid", {30'd0, out_valid, out_last}, 32'd2);
            if (c < 2) tick();
        end
        out_ready = 1'b1;
        repeat (2) tick();

        // LA with base R5: R0-R4, R6, R7, then R5 keeping k=5
        for (int i = 0; i < 5; i++) push(16'h4140 + 16'(i * 16'h0201), 16'h0038, 1'b1, 1'b0);
        push(16'h4D46, 16'h0038, 1'b1, 1'b0);
        push(16'h4F47, 16'h0038, 1'b1, 1'b0);
        push(16'h4B45, 16'h0038, 1'b1, 1'b1);
        send(16'hEA00, 16'h0038, waits);
        repeat (8) tick();

        // SA with base R5: no deferral, next instruction taken in the 8th output cycle
        for (int i = 0; i < 8; i++) push(16'h5140 + 16'(i * 16'h0201), 16'h0040, 1'b1, i == 7);
        push(16'h1298, 16'h0050, 1'b0, 1'b1);
        send(16'hFA00, 16'h0040, waits);
        repeat (6) tick();
        check("sa_in_ready_7th", 32'(in_ready), 32'd0);
        tick();
        check("sa_in_ready_8th", 32'(in_ready), 32'd1);
        send(16'h1298, 16'h0050, waits);
        check("sa_b2b_waits", 32'(waits), 32'd0);
        tick();

        // Reset in the middle of an LA expansion
        push(16'h4140, 16'h0080, 1'b1, 1'b0);
        push(16'h4341, 16'h0080, 1'b1, 1'b0);
        send(16'hEA00, 16'h0080, waits);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ir", 32'(out_ir), 32'h0);
        check("mrst_npc", 32'(out_npc), 32'h0);
        check("mrst_uop_last", {30'd0, out_uop, out_last}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("mrst_quiet", {30'd0, out_valid, in_ready}, 32'd1);

        // Flush during the second micro-op of LM 0xC416
        push(16'h4280, 16'h0060, 1'b1, 1'b0);
        send(16'hC416, 16'h0060, waits);
        tick();
        check("fl_second_uop", 32'(out_ir), 32'h4882);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("fl_no_more", 32'(out_valid), 32'd0);

        // Zero-mask LM is consumed silently; following ADD accepted at once
        push(16'h1298, 16'h0071, 1'b0, 1'b1);
        send(16'hC400, 16'h0070, waits);
        check("zm_no_output", {30'd0, out_valid, in_ready}, 32'd1);
        send(16'h1298, 16'h0071, waits);
        check("zm_next_waits", 32'(waits), 32'd0);
        repeat (3) tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
